// File: rtl/song_player.sv
// Melody sequencer: KEY[1] toggles play/stop and out_note gives the current tone half-period in clock cycles.
// Build option: define SONG_LOOP_EN to wrap to the first entry after the last one instead of stopping.
module song_player #(
    parameter int BEAT_TICKS = 12500000,
    parameter int SONG_LEN   = 16
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [18:0] out_note
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    localparam logic [31:0] BEAT_W   = 32'(BEAT_TICKS);
    localparam logic [3:0]  LAST_IDX = 4'(SONG_LEN - 1);

    logic        rst_n;
    logic        unused_s;

    logic        key_meta_q;
    logic        key_sync_q;
    logic        key_prev_q;
    logic        press_s;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  idx_q;
    logic [3:0]  idx_d;
    logic [31:0] dur_q;
    logic [31:0] dur_d;
    logic [18:0] out_note_q;
    logic [18:0] out_note_d;

    logic [5:0]  cur_entry_s;
    logic [3:0]  next_idx_s;

    assign rst_n    = KEY[0];
    assign unused_s = ^{KEY[3:2], SW[9:2]};

    // Song table: {note code, length in beats}.
    function automatic logic [5:0] rom_entry(input logic [3:0] idx);
        logic [5:0] e;
        case (idx)
            4'd0:    e = {4'd1, 2'd1};
            4'd1:    e = {4'd1, 2'd1};
            4'd2:    e = {4'd5, 2'd1};
            4'd3:    e = {4'd5, 2'd1};
            4'd4:    e = {4'd6, 2'd1};
            4'd5:    e = {4'd6, 2'd1};
            4'd6:    e = {4'd5, 2'd2};
            4'd7:    e = {4'd0, 2'd1};
            4'd8:    e = {4'd4, 2'd1};
            4'd9:    e = {4'd4, 2'd1};
            4'd10:   e = {4'd3, 2'd1};
            4'd11:   e = {4'd3, 2'd1};
            4'd12:   e = {4'd2, 2'd1};
            4'd13:   e = {4'd2, 2'd1};
            4'd14:   e = {4'd1, 2'd2};
            4'd15:   e = {4'd0, 2'd1};
            default: e = {4'd0, 2'd1};
        endcase
        return e;
    endfunction

    function automatic logic [18:0] note_half_period(input logic [3:0] code);
        logic [18:0] hp;
        case (code)
            4'd1:    hp = 19'd95420;
            4'd2:    hp = 19'd85034;
            4'd3:    hp = 19'd75758;
            4'd4:    hp = 19'd71633;
            4'd5:    hp = 19'd63776;
            4'd6:    hp = 19'd56818;
            4'd7:    hp = 19'd50607;
            4'd8:    hp = 19'd47710;
            default: hp = 19'd0;
        endcase
        return hp;
    endfunction

    // Counter load value for one entry: beats x tempo-scaled beat, minus one because the count ends at zero.
    function automatic logic [31:0] entry_load(input logic [3:0] idx, input logic [1:0] tempo);
        logic [5:0]  e;
        logic [31:0] beat;
        logic [31:0] total;
        e    = rom_entry(idx);
        beat = BEAT_W >> tempo;
        if (beat == 32'd0) begin
            beat = 32'd1;
        end else begin
            beat = beat;
        end
        case (e[1:0])
            2'd2:    total = beat << 1;
            2'd3:    total = (beat << 1) + beat;
            default: total = beat;
        endcase
        return total - 32'd1;
    endfunction

    assign press_s     = key_prev_q & ~key_sync_q;
    assign cur_entry_s = rom_entry(idx_q);
    assign next_idx_s  = idx_q + 4'd1;

    // KEY[1] synchronizer and falling-edge history; released level is 1.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_prev_q <= 1'b1;
        end else begin
            key_meta_q <= KEY[1];
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    // Sequencer next-state: a press always wins over an end-of-entry event.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        case (state_q)
            ST_IDLE: begin
                if (press_s) begin
                    state_d = ST_PLAY;
                    idx_d   = 4'd0;
                    dur_d   = entry_load(4'd0, SW[1:0]);
                end else begin
                    idx_d   = 4'd0;
                    dur_d   = 32'd0;
                end
            end
            ST_PLAY: begin
                if (press_s) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                    dur_d   = 32'd0;
                end else if (dur_q == 32'd0) begin
                    if (idx_q == LAST_IDX) begin
`ifdef SONG_LOOP_EN
                        idx_d   = 4'd0;
                        dur_d   = entry_load(4'd0, SW[1:0]);
`else
                        state_d = ST_IDLE;
                        idx_d   = 4'd0;
                        dur_d   = 32'd0;
`endif
                    end else begin
                        idx_d = next_idx_s;
                        dur_d = entry_load(next_idx_s, SW[1:0]);
                    end
                end else begin
                    dur_d = dur_q - 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 4'd0;
                dur_d   = 32'd0;
            end
        endcase
    end

    // Output follows the index one cycle later and is forced silent outside PLAY.
    always_comb begin
        out_note_d = 19'd0;
        if (state_q == ST_PLAY) begin
            out_note_d = note_half_period(cur_entry_s[5:2]);
        end else begin
            out_note_d = 19'd0;
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            dur_q      <= 32'd0;
            out_note_q <= 19'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dur_q      <= dur_d;
            out_note_q <= out_note_d;
        end
    end

    assign out_note = out_note_q;

endmodule

// File: tb/tb_song_player.sv
// Scoreboard bench for song_player: expected note segments are queued by the stimulus and checked by a monitor.
module tb_song_player;

    localparam int BT = 10;

    logic        CLOCK_50 = 1'b0;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [18:0] out_note;

    song_player #(
        .BEAT_TICKS(BT),
        .SONG_LEN  (16)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .KEY     (KEY),
        .SW      (SW),
        .out_note(out_note)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // note: expected value; len: expected cycles (0 = not checked); lat: check press-to-change latency
    typedef struct {
        int note;
        int len;
        bit lat;
    } seg_t;

    seg_t exp_q[$];
    seg_t seg;
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   press_cyc = 0;
    int   prev_note = 0;
    int   run       = 0;
    int   cur_len   = 0;

    // Monitor: on every change of out_note, close the previous segment and match the new value.
    always @(negedge CLOCK_50) begin
        cyc = cyc + 1;
        if (KEY[0] == 1'b0) begin
            prev_note = 0;
            run       = 0;
            cur_len   = 0;
        end else if (int'(out_note) != prev_note) begin
            if (cur_len != 0) begin
                total++;
                if (run != cur_len) begin
                    bad++;
                    $display("FAIL seg_len note=%0d got=%0d cycles want=%0d", prev_note, run, cur_len);
                end
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change got=%0d want=%0d", out_note, prev_note);
                cur_len = 0;
            end else begin
                seg = exp_q.pop_front();
                if (int'(out_note) != seg.note) begin
                    bad++;
                    $display("FAIL note got=%0d want=%0d", out_note, seg.note);
                end
                if (seg.lat) begin
                    // pin driven just after an edge: 4 clock edges later the new note is seen at this sample
                    total++;
                    if (cyc - press_cyc > 5) begin
                        bad++;
                        $display("FAIL press_latency got=%0d want<=5", cyc - press_cyc);
                    end
                end
                cur_len = seg.len;
            end
            prev_note = int'(out_note);
            run       = 1;
        end else begin
            run++;
        end
    end

    task automatic push_seg(input int n, input int l, input bit lt);
        seg_t s;
        s.note = n;
        s.len  = l;
        s.lat  = lt;
        exp_q.push_back(s);
    endtask

    task automatic press();
        @(posedge CLOCK_50);
        #1;
        KEY[1]    = 1'b0;
        press_cyc = cyc;
        repeat (5) @(posedge CLOCK_50);
        #1;
        KEY[1] = 1'b1;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge CLOCK_50);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_now(input string name, input int want);
        total++;
        if (int'(out_note) != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, out_note, want);
        end
    endtask

    // Whole-song segment list; identical neighbouring entries merge into one segment.
    task automatic push_song(input int b);
        push_seg(95420, 2 * b, 1'b1);
        push_seg(63776, 2 * b, 1'b0);
        push_seg(56818, 2 * b, 1'b0);
        push_seg(63776, 2 * b, 1'b0);
        push_seg(0,     b,     1'b0);
        push_seg(71633, 2 * b, 1'b0);
        push_seg(75758, 2 * b, 1'b0);
        push_seg(85034, 2 * b, 1'b0);
        push_seg(95420, 2 * b, 1'b0);
`ifdef SONG_LOOP_EN
        push_seg(0,     b,     1'b0);
        push_seg(95420, 0,     1'b0);
`else
        push_seg(0,     0,     1'b0);
`endif
    endtask

    task automatic finish_song();
`ifdef SONG_LOOP_EN
        push_seg(0, 0, 1'b1);
        press();
        wait_drain(20);
        repeat (20) @(negedge CLOCK_50);
        check_now("loop_stop", 0);
`else
        repeat (60) @(negedge CLOCK_50);
        check_now("end_idle", 0);
`endif
    endtask

    initial begin
        KEY = 4'b1111;
        SW  = 10'd0;
        #1;
        KEY[0] = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check_now("in_reset", 0);
        KEY[0] = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check_now("after_reset", 0);

        // start, then stop partway through the G segment
        push_seg(95420, 2 * BT, 1'b1);
        push_seg(63776, 0, 1'b0);
        press();
        wait_drain(200);
        repeat (5) @(posedge CLOCK_50);
        push_seg(0, 0, 1'b1);
        press();
        wait_drain(20);
        repeat (50) @(negedge CLOCK_50);
        check_now("stop_hold", 0);

        // restart from entry 0 and play to the end at normal tempo
        push_song(BT);
        press();
        wait_drain(600);
        finish_song();

        // double tempo
        SW = 10'b0000000001;
        push_song(BT / 2);
        press();
        wait_drain(400);
        finish_song();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
